codeword_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream codeword decoder between NUM_CH sync-detected byte streams. Each requester is an AXI-stream byte channel that emits whole codewords terminated by tlast. The block grants one channel for exactly one codeword, forwards it through a registered output stage, and checks codeword length. It sits between the per-channel sync detectors and the single RS decoder instance.

---
 rtl/codeword_arbiter_if.sv | 13 +
 rtl/codeword_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_codeword_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codeword_arbiter_if.sv
// Byte-lane AXI-stream bundle; LANES parallel byte channels with per-lane handshake.
// The arbiter takes the slave view on its request side and the master view downstream.
interface codeword_arbiter_if #(
  parameter int unsigned LANES = 1
) ();
  logic [8*LANES-1:0] tdata;
  logic [LANES-1:0]   tvalid;
  logic [LANES-1:0]   tlast;
  logic [LANES-1:0]   tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/codeword_arbiter.sv
// Round-robin arbiter sharing one codeword decoder between NUM_CH byte streams.
// Optional stall abort is compiled in when ARB_TIMEOUT_EN is defined.
module codeword_arbiter #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CODEWORD_LEN = 255,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                core_clk,
  input  logic                rst_n,
  codeword_arbiter_if.slave   s_axis,
  codeword_arbiter_if.master  m_axis,
  output logic [2:0]          grant_ch,
  output logic                busy,
  output logic                len_err,
  output logic                timeout
);

  localparam int unsigned       CW       = $clog2(CODEWORD_LEN + 1);
  localparam logic [CW-1:0]     LAST_CNT = CW'(CODEWORD_LEN - 1);
  localparam logic [2:0]        LAST_CH  = 3'(NUM_CH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mdata_q, mdata_d;
  logic          mvalid_q, mvalid_d;
  logic          mlast_q, mlast_d;
  logic          len_err_q, len_err_d;

  logic [NUM_CH-1:0] tready;
  logic [7:0]        sel_data;
  logic              sel_valid, sel_last;
  logic              rdy, accept, cnt_full, eff_last;
  logic              hit;
  logic [2:0]        hit_ch, next_ptr;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned   SW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYC - 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;
`endif

  // Granted channel's lane.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_q == 3'(i)) begin
        sel_data  = s_axis.tdata[8*i +: 8];
        sel_valid = s_axis.tvalid[i];
        sel_last  = s_axis.tlast[i];
      end
    end
  end

  // First requester at or after ptr, wrapping modulo NUM_CH.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    hit    = 1'b0;
    hit_ch = ptr_q;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!hit && s_axis.tvalid[idx]) begin
        hit    = 1'b1;
        hit_ch = 3'(idx);
      end
    end
  end

  always_comb begin
    rdy = (state_q == BUSY) && (!mvalid_q || m_axis.tready[0]);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tready[i] = rdy && (grant_q == 3'(i));
    end
  end

  assign accept   = rdy && sel_valid;
  assign cnt_full = (cnt_q == LAST_CNT);
  assign eff_last = sel_last || cnt_full;
  assign next_ptr = (grant_q == LAST_CH) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mdata_d   = mdata_q;
    mvalid_d  = mvalid_q;
    mlast_d   = mlast_q;
    len_err_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = 1'b0;
`endif

    if (accept) begin
      mdata_d   = sel_data;
      mvalid_d  = 1'b1;
      mlast_d   = eff_last;
      cnt_d     = cnt_q + CW'(1);
      // Error when tlast disagrees with the length count in either direction.
      len_err_d = eff_last && (sel_last != cnt_full);
    end else if (m_axis.tready[0]) begin
      mvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        if (hit) begin
          grant_d = hit_ch;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && eff_last) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end
`ifdef ARB_TIMEOUT_EN
        if (sel_valid) begin
          stall_d = '0;
        end else if (stall_q == STALL_MAX) begin
          stall_d   = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
          ptr_d     = next_ptr;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      mdata_q   <= '0;
      mvalid_q  <= 1'b0;
      mlast_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mdata_q   <= mdata_d;
      mvalid_q  <= mvalid_d;
      mlast_q   <= mlast_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign s_axis.tready    = tready;
  assign m_axis.tdata     = mdata_q;
  assign m_axis.tvalid[0] = mvalid_q;
  assign m_axis.tlast[0]  = mlast_q;
  assign grant_ch         = grant_q;
  assign busy             = (state_q == BUSY);
  assign len_err          = len_err_q;

endmodule

// File: tb/tb_codeword_arbiter.sv
// Scoreboard bench for codeword_arbiter: per-channel byte sources, expected beats
// queued at input acceptance and compared as they leave the output stage.
module tb_codeword_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned LEN = 255;
  localparam int unsigned TO  = 16;

  logic       core_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] grant_ch;
  logic       busy, len_err, timeout;

  always #5 core_clk = ~core_clk;

  codeword_arbiter_if #(.LANES(NCH)) s_if ();
  codeword_arbiter_if #(.LANES(1))   m_if ();

  codeword_arbiter #(
    .NUM_CH      (NCH),
    .CODEWORD_LEN(LEN),
    .TIMEOUT_CYC (TO)
  ) dut (
    .core_clk(core_clk),
    .rst_n   (rst_n),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .grant_ch(grant_ch),
    .busy    (busy),
    .len_err (len_err),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source queues hold {tlast, tdata}; head is presented while non-empty.
  logic [8:0]        src_q [NCH][$];
  logic [NCH-1:0]    fire_mask = '0;
  int unsigned       cyc = 0;
  bit                rr_mode = 1'b0;
  int unsigned       phase = 0;

  logic [9:0]        exp_q [$];
  int                got_order [$];
  int unsigned       got_cyc [$];
  int unsigned       mcnt;
  int                last_ch;
  int                le_seen, to_seen, last_cnt, n_out;
  int unsigned       to_cyc;
  int unsigned       last_fire [NCH];
  bit                prev_stall;
  logic [7:0]        prev_data;

  always @(posedge core_clk) cyc <= cyc + 1;

  initial begin
    s_if.tvalid = '0;
    s_if.tdata  = '0;
    s_if.tlast  = '0;
    m_if.tready = '1;
    forever begin
      @(posedge core_clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        logic [8:0] h;
        if (fire_mask[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        if (src_q[c].size() > 0) begin
          h = src_q[c][0];
          s_if.tvalid[c]        = 1'b1;
          s_if.tdata[8*c +: 8]  = h[7:0];
          s_if.tlast[c]         = h[8];
        end else begin
          s_if.tvalid[c]        = 1'b0;
          s_if.tdata[8*c +: 8]  = 8'h00;
          s_if.tlast[c]         = 1'b0;
        end
      end
      m_if.tready[0] = rr_mode ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b1;
      phase++;
    end
  end

  always @(negedge core_clk) begin
    if (!rst_n) begin
      exp_q.delete();
      got_order.delete();
      got_cyc.delete();
      mcnt       = 0;
      last_ch    = -1;
      le_seen    = 0;
      to_seen    = 0;
      last_cnt   = 0;
      n_out      = 0;
      prev_stall = 1'b0;
      fire_mask  = '0;
    end else begin
      if (len_err) begin
        le_seen++;
        check("len_err_align", (exp_q.size() > 0) ? 32'(exp_q[0][9]) : 32'd0, 1);
        check("len_err_valid", m_if.tvalid[0], 1);
      end
      if (timeout) begin
        to_seen++;
        to_cyc = cyc;
      end
      if (prev_stall) begin
        check("hold_valid", m_if.tvalid[0], 1);
        check("hold_data", m_if.tdata, prev_data);
      end
      if (m_if.tvalid[0] && !m_if.tready[0]) check("tready_backpressure", s_if.tready, 0);
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        n_out++;
        if (m_if.tlast[0]) last_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("data", m_if.tdata, e[7:0]);
          check("last", m_if.tlast[0], e[8]);
        end
      end
      prev_stall = m_if.tvalid[0] && !m_if.tready[0];
      prev_data  = m_if.tdata;

      fire_mask = s_if.tvalid & s_if.tready;
      if (s_if.tready != '0) check("tready_onehot", $onehot(s_if.tready), 1);
      for (int c = 0; c < NCH; c++) begin
        if (fire_mask[c]) begin
          logic [8:0] h;
          bit full, eff, le;
          h = src_q[c][0];
          if (c != last_ch) mcnt = 0;
          if (mcnt == 0) begin
            got_order.push_back(c);
            got_cyc.push_back(cyc);
          end
          full = (mcnt == LEN - 1);
          eff  = h[8] || full;
          le   = eff && (h[8] != full);
          exp_q.push_back({le, eff, h[7:0]});
          mcnt         = eff ? 0 : mcnt + 1;
          last_ch      = c;
          last_fire[c] = cyc;
        end
      end
    end
  end

  function automatic int ord(input int i);
    return (i < got_order.size()) ? got_order[i] : -1;
  endfunction

  function automatic int unsigned ocyc(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk_reset();
    check("rst_m_tvalid", m_if.tvalid[0], 0);
    check("rst_m_tdata",  m_if.tdata, 0);
    check("rst_m_tlast",  m_if.tlast[0], 0);
    check("rst_s_tready", s_if.tready, 0);
    check("rst_grant_ch", grant_ch, 0);
    check("rst_busy",     busy, 0);
    check("rst_len_err",  len_err, 0);
    check("rst_timeout",  timeout, 0);
  endtask

  task automatic do_reset();
    @(posedge core_clk);
    #2;
    rst_n   = 1'b0;
    rr_mode = 1'b0;
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    repeat (2) @(posedge core_clk);
    #2;
    chk_reset();
    rst_n = 1'b1;
  endtask

  task automatic send(input int c, input int n, input int last_at, input int base);
    for (int i = 0; i < n; i++) src_q[c].push_back({(i == last_at), 8'(base + i)});
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      @(posedge core_clk);
      #2;
      k++;
      done = (exp_q.size() == 0) && !busy && !m_if.tvalid[0];
      for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) done = 1'b0;
    end
    check("drained_in_budget", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start;

    do_reset();

    // Single channel, full-length codeword.
    start = cyc + 1;
    send(1, 255, 254, 0);
    wait_done(1000);
    check("t1_grants", got_order.size(), 1);
    check("t1_grant_seq", ord(0), 1);
    check("t1_first_ready", ocyc(0) - start, 1);
    check("t1_grant_ch", grant_ch, 1);
    check("t1_len_err", le_seen, 0);
    check("t1_lasts", last_cnt, 1);
    check("t1_beats", n_out, 255);

    // All channels contending, two codewords each.
    do_reset();
    start = cyc + 1;
    for (int c = 0; c < NCH; c++) begin
      send(c, 255, 254, c * 40);
      send(c, 255, 254, c * 40 + 100);
    end
    wait_done(4000);
    check("t2_grants", got_order.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("t2_grant_seq", ord(k), k % 4);
      check("t2_start_cycle", ocyc(k) - start, 256 * k + 1);
    end
    check("t2_len_err", le_seen, 0);
    check("t2_lasts", last_cnt, 8);
    check("t2_beats", n_out, 2040);

    // Short codeword on channel 2, then channel 3.
    do_reset();
    send(2, 100, 99, 8'h10);
    send(3, 255, 254, 8'h80);
    wait_done(1000);
    check("t3_grant0", ord(0), 2);
    check("t3_grant1", ord(1), 3);
    check("t3_len_err", le_seen, 1);
    check("t3_lasts", last_cnt, 2);
    check("t3_beats", n_out, 355);

    // Channel 0 never sends tlast: forced split every LEN bytes.
    do_reset();
    start = cyc + 1;
    send(0, 510, -1, 0);
    wait_done(1500);
    check("t4_grant0", ord(0), 0);
    check("t4_grant1", ord(1), 0);
    check("t4_regrant_cycle", ocyc(1) - start, 257);
    check("t4_len_err", le_seen, 2);
    check("t4_lasts", last_cnt, 2);
    check("t4_beats", n_out, 510);

    // Downstream ready pattern 1,0,0,1.
    do_reset();
    rr_mode = 1'b1;
    send(1, 255, 254, 8'h33);
    send(3, 30, 29, 8'h99);
    wait_done(3000);
    rr_mode = 1'b0;
    check("t5_grant0", ord(0), 1);
    check("t5_grant1", ord(1), 3);
    check("t5_len_err", le_seen, 1);
    check("t5_lasts", last_cnt, 2);
    check("t5_beats", n_out, 285);

    // Channel 1 stalls mid-codeword while channel 2 waits.
    do_reset();
    send(1, 10, -1, 8'h50);
    send(2, 255, 254, 8'hA0);
`ifdef ARB_TIMEOUT_EN
    wait_done(1000);
    check("t6_grant0", ord(0), 1);
    check("t6_grant1", ord(1), 2);
    check("t6_timeouts", to_seen, 1);
    check("t6_timeout_delay", to_cyc - last_fire[1], TO + 1);
    check("t6_len_err", le_seen, 0);
    check("t6_lasts", last_cnt, 1);
    check("t6_beats", n_out, 265);
`else
    repeat (60) @(posedge core_clk);
    #2;
    check("t6_busy_held", busy, 1);
    check("t6_grant_held", grant_ch, 1);
    check("t6_grants", got_order.size(), 1);
    check("t6_ch2_waiting", src_q[2].size(), 255);
    check("t6_timeouts", to_seen, 0);
    check("t6_beats", n_out, 10);
    rst_n = 1'b0;
    #1;
    chk_reset();
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
